// File: rtl/icosoc_syncfifo_if.sv
// Handshake bundle between an icosoc_syncfifo and its producer/consumer.
//   master : the peripheral side, drives push/pop/flush/clear_err requests
//   slave  : the FIFO, drives data, level, threshold and error flags
// clk and reset are not part of the bundle; they are plain module ports.
interface icosoc_syncfifo_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
);
  localparam int LBITS = $clog2(DEPTH + 1);

  logic             in_shift;
  logic [WIDTH-1:0] in_data;
  logic             in_full;
  logic             in_afull;
  logic             out_pop;
  logic [WIDTH-1:0] out_data;
  logic             out_nempty;
  logic             out_aempty;
  logic [LBITS-1:0] level;
  logic             flush;
  logic             clear_err;
  logic             overflow;
  logic             underflow;

  modport master (
    output in_shift, in_data, out_pop, flush, clear_err,
    input  in_full, in_afull, out_data, out_nempty, out_aempty, level,
           overflow, underflow
  );

  modport slave (
    input  in_shift, in_data, out_pop, flush, clear_err,
    output in_full, in_afull, out_data, out_nempty, out_aempty, level,
           overflow, underflow
  );
endinterface

// File: rtl/icosoc_syncfifo.sv
// Single-clock FIFO with arbitrary depth, level count, programmable
// almost-full/almost-empty thresholds, synchronous flush, sticky
// overflow/underflow flags and a selectable FWFT or registered-read output.
// Ports:
//   clk   - clock, all state on the rising edge
//   reset - asynchronous, active-high reset
//   bus   - icosoc_syncfifo_if.slave: push/pop/flush/clear_err requests in,
//           out_data, level, in_full/in_afull, out_nempty/out_aempty,
//           overflow/underflow out
module icosoc_syncfifo #(
  parameter int WIDTH        = 8,
  parameter int DEPTH        = 16,
  parameter int AFULL_LEVEL  = DEPTH - 1,
  parameter int AEMPTY_LEVEL = 1,
  parameter int FWFT         = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  icosoc_syncfifo_if.slave      bus
);
  localparam int LBITS = $clog2(DEPTH + 1);
  localparam int PBITS = (DEPTH > 2) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PBITS-1:0] wptr, rptr, wptr_nxt, rptr_nxt;
  logic [LBITS-1:0] count;
  logic [WIDTH-1:0] dout;
  logic             ovf, unf;
  logic             full, nempty, push, pop;

  assign full   = (count == LBITS'(DEPTH));
  assign nempty = (count != '0);
  assign push   = bus.in_shift && !full && !bus.flush;
  assign pop    = bus.out_pop && nempty && !bus.flush;

  // Pointers wrap explicitly so any DEPTH works, not just powers of two.
  assign wptr_nxt = (wptr == PBITS'(DEPTH - 1)) ? '0 : wptr + PBITS'(1);
  assign rptr_nxt = (rptr == PBITS'(DEPTH - 1)) ? '0 : rptr + PBITS'(1);

  // Storage is never reset or cleared; only pointers and level define validity.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= bus.in_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      dout  <= '0;
      ovf   <= 1'b0;
      unf   <= 1'b0;
    end else begin
      if (bus.flush) begin
        wptr  <= '0;
        rptr  <= '0;
        count <= '0;
        dout  <= '0;
      end else begin
        if (push) wptr <= wptr_nxt;
        if (pop)  rptr <= rptr_nxt;
        if (push && !pop)      count <= count + LBITS'(1);
        else if (pop && !push) count <= count - LBITS'(1);

        if (FWFT != 0) begin
          // dout always mirrors the head. On a pop the next head is either
          // the following memory entry or, when the last word leaves, the
          // word being pushed in the same cycle (not yet readable from mem).
          if (pop) begin
            if (count == LBITS'(1)) dout <= push ? bus.in_data : '0;
            else                    dout <= mem[rptr_nxt];
          end else if (push && !nempty) begin
            dout <= bus.in_data;
          end
        end else begin
          if (pop) dout <= mem[rptr];
        end
      end

      // Setting wins over a same-cycle clear; flush cycles never set.
      if (bus.in_shift && full && !bus.flush) ovf <= 1'b1;
      else if (bus.clear_err)                 ovf <= 1'b0;
      if (bus.out_pop && !nempty && !bus.flush) unf <= 1'b1;
      else if (bus.clear_err)                   unf <= 1'b0;
    end
  end

  assign bus.in_full    = full;
  assign bus.in_afull   = (count >= LBITS'(AFULL_LEVEL));
  assign bus.out_nempty = nempty;
  assign bus.out_aempty = (count <= LBITS'(AEMPTY_LEVEL));
  assign bus.level      = count;
  assign bus.out_data   = dout;
  assign bus.overflow   = ovf;
  assign bus.underflow  = unf;
endmodule

// File: tb/tb_icosoc_syncfifo.sv
module tb_icosoc_syncfifo;
  localparam int W  = 8;
  localparam int D  = 5;
  localparam int AF = 4;
  localparam int AE = 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  icosoc_syncfifo_if #(.WIDTH(W), .DEPTH(D)) bus_a ();
  icosoc_syncfifo_if #(.WIDTH(W), .DEPTH(D)) bus_b ();

  icosoc_syncfifo #(.WIDTH(W), .DEPTH(D), .AFULL_LEVEL(AF), .AEMPTY_LEVEL(AE), .FWFT(1))
    dut_a (.clk(clk), .reset(reset), .bus(bus_a));
  icosoc_syncfifo #(.WIDTH(W), .DEPTH(D), .AFULL_LEVEL(AF), .AEMPTY_LEVEL(AE), .FWFT(0))
    dut_b (.clk(clk), .reset(reset), .bus(bus_b));

  // Reference model: a queue of stored words plus the last popped word.
  logic [W-1:0] q[$];
  logic [W-1:0] last_pop;
  logic         m_ovf, m_unf;
  int           n_cmp = 0;
  int           n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string ctx);
    int sz;
    sz = q.size();
    chk({ctx, " level_a"},   32'(bus_a.level),      32'(sz));
    chk({ctx, " level_b"},   32'(bus_b.level),      32'(sz));
    chk({ctx, " full"},      32'(bus_a.in_full),    32'(sz == D));
    chk({ctx, " afull"},     32'(bus_a.in_afull),   32'(sz >= AF));
    chk({ctx, " nempty"},    32'(bus_a.out_nempty), 32'(sz != 0));
    chk({ctx, " aempty"},    32'(bus_a.out_aempty), 32'(sz <= AE));
    chk({ctx, " fwft_data"}, 32'(bus_a.out_data),   (sz != 0) ? 32'(q[0]) : 32'd0);
    chk({ctx, " reg_data"},  32'(bus_b.out_data),   32'(last_pop));
    chk({ctx, " ovf_a"},     32'(bus_a.overflow),   32'(m_ovf));
    chk({ctx, " unf_a"},     32'(bus_a.underflow),  32'(m_unf));
    chk({ctx, " ovf_b"},     32'(bus_b.overflow),   32'(m_ovf));
    chk({ctx, " unf_b"},     32'(bus_b.underflow),  32'(m_unf));
  endtask

  task automatic model_reset();
    q.delete();
    last_pop = '0;
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  task automatic drive(input logic sh, input logic [W-1:0] din, input logic pp,
                       input logic fl, input logic clr);
    bus_a.in_shift = sh;  bus_b.in_shift = sh;
    bus_a.in_data  = din; bus_b.in_data  = din;
    bus_a.out_pop  = pp;  bus_b.out_pop  = pp;
    bus_a.flush    = fl;  bus_b.flush    = fl;
    bus_a.clear_err = clr; bus_b.clear_err = clr;
  endtask

  // One clock of stimulus, model update from the pre-edge state, then check.
  task automatic step(input string ctx, input logic sh, input logic [W-1:0] din,
                      input logic pp, input logic fl, input logic clr);
    bit was_full, was_empty;
    @(negedge clk);
    drive(sh, din, pp, fl, clr);
    @(posedge clk);
    was_full  = (q.size() == D);
    was_empty = (q.size() == 0);
    if (fl) begin
      q.delete();
      last_pop = '0;
    end else begin
      if (pp && !was_empty) last_pop = q.pop_front();
      if (sh && !was_full)  q.push_back(din);
    end
    if (sh && was_full && !fl)  m_ovf = 1'b1; else if (clr) m_ovf = 1'b0;
    if (pp && was_empty && !fl) m_unf = 1'b1; else if (clr) m_unf = 1'b0;
    #1;
    check_all(ctx);
  endtask

  initial begin
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    model_reset();
    reset = 1'b1;
    #12;
    check_all("reset");
    @(negedge clk);
    reset = 1'b0;

    // Fill to full, one rejected push, drain in order.
    for (int i = 1; i <= 5; i++) step("fill", 1'b1, W'(i), 1'b0, 1'b0, 1'b0);
    step("ovf_push", 1'b1, 8'h06, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step("drain", 1'b0, '0, 1'b1, 1'b0, 1'b0);
    step("clr_ovf", 1'b0, '0, 1'b0, 1'b0, 1'b1);

    // Pointer wrap under sustained push+pop.
    step("wrap_pre", 1'b1, 8'h40, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 13; i++) step("wrap", 1'b1, W'(8'h41 + i), 1'b1, 1'b0, 1'b0);
    step("wrap_post", 1'b0, '0, 1'b1, 1'b0, 1'b0);

    // Bypass at level 1.
    step("byp_pre", 1'b1, 8'hAA, 1'b0, 1'b0, 1'b0);
    step("bypass", 1'b1, 8'hBB, 1'b1, 1'b0, 1'b0);

    // Threshold walk up to 4, then flush with a push while at level 3.
    step("thr2", 1'b1, 8'hC2, 1'b0, 1'b0, 1'b0);
    step("thr3", 1'b1, 8'hC3, 1'b0, 1'b0, 1'b0);
    step("thr4", 1'b1, 8'hC4, 1'b0, 1'b0, 1'b0);
    step("thr_dn", 1'b0, '0, 1'b1, 1'b0, 1'b0);
    step("flush", 1'b1, 8'hDD, 1'b0, 1'b1, 1'b0);

    // Sticky underflow behaviour.
    step("unf_set", 1'b0, '0, 1'b1, 1'b0, 1'b0);
    step("unf_clr_pop", 1'b0, '0, 1'b1, 1'b0, 1'b1);
    step("unf_clr", 1'b0, '0, 1'b0, 1'b0, 1'b1);

    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      step("rand", ($urandom_range(99) < 55), W'($urandom), ($urandom_range(99) < 45),
           ($urandom_range(99) < 3), ($urandom_range(99) < 8));
    end

    // Asynchronous reset mid-burst, checked before any clock edge.
    for (int i = 0; i < 3; i++) step("burst", 1'b1, W'(8'hE0 + i), 1'b0, 1'b0, 1'b0);
    step("burst_ovf", 1'b1, 8'hE3, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check_all("async_rst");
    @(negedge clk);
    reset = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    step("post_rst", 1'b1, 8'h5A, 1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
